// File: rtl/result_bcd_formatter.sv
// result_bcd_formatter: sequential double-dabble binary-to-BCD converter with ASCII digit output.
// Optional LEADING_ZERO_BLANK_EN replaces leading zero digits in ascii_out with spaces.
module result_bcd_formatter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [8*DIGITS-1:0]   ascii_out
);
  localparam int CW = $clog2(WIDTH+1);
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [8*DIGITS-1:0] RST_ASCII = {{(DIGITS-1){8'h20}}, 8'h30};
`else
  localparam logic [8*DIGITS-1:0] RST_ASCII = {DIGITS{8'h30}};
`endif
  if (64'd10 ** DIGITS <= (64'd1 << WIDTH) - 64'd1) begin : g_bad_digits
    $error("result_bcd_formatter: DIGITS too small for WIDTH");
  end
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ADJ, S_SHIFT, S_DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0]    r_shift;
  logic [4*DIGITS-1:0] r_bcd, w_adj, w_bcd_shl;
  logic [CW-1:0]       r_count, w_count_inc;
  logic [8*DIGITS-1:0] w_ascii;
  logic                w_last;
  assign w_count_inc = r_count + CW'(1);
  assign w_last      = w_count_inc == CW'(WIDTH);
  assign w_bcd_shl   = {r_bcd[4*DIGITS-2:0], r_shift[WIDTH-1]};
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++)
      w_adj[4*i+:4] = r_bcd[4*i+:4] >= 4'd5 ? r_bcd[4*i+:4] + 4'd3 : r_bcd[4*i+:4];
  end
`ifdef LEADING_ZERO_BLANK_EN
  logic w_lead;
  always_comb begin
    w_ascii = '0;
    w_lead  = 1'b1;
    for (int i = DIGITS-1; i >= 0; i--) begin
      w_lead = w_lead && i != 0 && w_bcd_shl[4*i+:4] == 4'd0;
      w_ascii[8*i+:8] = w_lead ? 8'h20 : {4'h3, w_bcd_shl[4*i+:4]};
    end
  end
`else
  always_comb begin
    w_ascii = '0;
    for (int i = 0; i < DIGITS; i++)
      w_ascii[8*i+:8] = {4'h3, w_bcd_shl[4*i+:4]};
  end
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  always_comb
    w_next = r_state == S_IDLE  ? (start ? S_LOAD : S_IDLE) :
             r_state == S_LOAD  ? S_ADJ :
             r_state == S_ADJ   ? S_SHIFT :
             r_state == S_SHIFT ? (w_last ? S_DONE : S_ADJ) : S_IDLE;
  always_comb begin
    busy  = r_state != S_IDLE;
    valid = r_state == S_DONE;
  end
  // Final digits are taken from the shifted value so outputs update on the edge entering DONE.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_shift   <= '0;
      r_bcd     <= '0;
      r_count   <= '0;
      bcd_out   <= '0;
      ascii_out <= RST_ASCII;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_shift <= bin_in;
        r_bcd   <= '0;
        r_count <= '0;
      end
      if (r_state == S_ADJ) r_bcd <= w_adj;
      if (r_state == S_SHIFT) begin
        r_bcd   <= w_bcd_shl;
        r_shift <= r_shift << 1;
        r_count <= w_count_inc;
        if (w_last) begin
          bcd_out   <= w_bcd_shl;
          ascii_out <= w_ascii;
        end
      end
    end
endmodule

// File: tb/tb_result_bcd_formatter.sv
// tb_result_bcd_formatter: directed and random checks of result_bcd_formatter against a decimal-arithmetic model.
module tb_result_bcd_formatter;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [15:0] bin_in = '0;
  logic        busy, valid;
  logic [19:0] bcd_out;
  logic [39:0] ascii_out;
  int checks = 0, errors = 0, n_valid = 0, n_exp = 0;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [39:0] RST_ASCII = 40'h2020202030;
`else
  localparam logic [39:0] RST_ASCII = 40'h3030303030;
`endif

  result_bcd_formatter #(.WIDTH(16), .DIGITS(5)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .valid(valid), .bcd_out(bcd_out), .ascii_out(ascii_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (valid) n_valid++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int v, output logic [19:0] bcd, output logic [39:0] asc);
    int d[5];
    int x = v;
    bit lead = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d[i] = x % 10;
      x = x / 10;
    end
    for (int i = 4; i >= 0; i--) begin
      bcd[4*i+:4] = 4'(d[i]);
`ifdef LEADING_ZERO_BLANK_EN
      if (lead && i > 0 && d[i] == 0) asc[8*i+:8] = 8'h20;
      else begin
        asc[8*i+:8] = 8'(8'h30 + d[i]);
        lead = 1'b0;
      end
`else
      asc[8*i+:8] = 8'(8'h30 + d[i]);
`endif
    end
  endfunction

  // Called at a negedge in IDLE; returns at a negedge in the IDLE cycle after DONE.
  task automatic convert(input logic [15:0] v, input int inject, input string tag);
    logic [19:0] eb;
    logic [39:0] ea;
    int lat = 0, blow = 0;
    model(int'(v), eb, ea);
    bin_in = v;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bin_in = 16'($urandom);
    while (!valid && lat < 40) begin
      if (!busy) blow++;
      if (lat == inject) begin
        start = 1'b1;
        bin_in = 16'd77;
      end else start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(lat), 64'd33);
    chk({tag, " valid"}, 64'(valid), 64'd1);
    chk({tag, " busy_in_done"}, 64'(busy), 64'd1);
    chk({tag, " busy_dropouts"}, 64'(blow), 64'd0);
    chk({tag, " bcd"}, 64'(bcd_out), 64'(eb));
    chk({tag, " ascii"}, 64'(ascii_out), 64'(ea));
    n_exp++;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " valid_pulse"}, 64'(valid), 64'd0);
    chk({tag, " busy_after"}, 64'(busy), 64'd0);
    chk({tag, " bcd_held"}, 64'(bcd_out), 64'(eb));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst valid", 64'(valid), 64'd0);
    chk("rst bcd", 64'(bcd_out), 64'd0);
    chk("rst ascii", 64'(ascii_out), 64'(RST_ASCII));
    rst = 1'b1;
    @(negedge clk);
    convert(16'd1024, -1, "t1");
    chk("t1 bcd_const", 64'(bcd_out), 64'h01024);
    convert(16'd65535, -1, "t2");
    chk("t2 bcd_const", 64'(bcd_out), 64'h65535);
    convert(16'd0, -1, "t3");
    chk("t3 bcd_const", 64'(bcd_out), 64'h00000);
    convert(16'd9, 10, "t4a");
    chk("t4a bcd_const", 64'(bcd_out), 64'h00009);
    convert(16'd10, -1, "t4b");
    chk("t4b bcd_const", 64'(bcd_out), 64'h00010);
    bin_in = 16'd4096;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5 busy", 64'(busy), 64'd0);
    chk("t5 valid", 64'(valid), 64'd0);
    chk("t5 bcd", 64'(bcd_out), 64'd0);
    chk("t5 ascii", 64'(ascii_out), 64'(RST_ASCII));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    convert(16'd81, -1, "t5b");
    chk("t5b bcd_const", 64'(bcd_out), 64'h00081);
    for (int k = 0; k < 200; k++) begin
      logic [15:0] r;
      r = 16'($urandom);
      if (k % 50 == 0) r = 16'($urandom_range(0, 9));
      convert(r, (k % 7 == 0) ? int'($urandom_range(0, 30)) : -1, "rand");
    end
    repeat (2) @(negedge clk);
    chk("valid_count", 64'(n_valid), 64'(n_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
